// File: rtl/spi_slave_regfile.sv
// SPI mode-0 responder serving a 64-byte register file (ADXL362-style read/write commands).
// SPI pins are oversampled in clk_i; a fabric load port shares the writable registers.
module spi_slave_regfile #(
    parameter logic [7:0] DEVID_AD  = 8'hAD,
    parameter logic [7:0] DEVID_MST = 8'h1D,
    parameter logic [7:0] PARTID    = 8'hF2
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       sclk_i,
    input  logic       cs_n_i,
    input  logic       mosi_i,
    output logic       miso_o,
    output logic       miso_oe_o,
    input  logic       ld_en_i,
    input  logic [5:0] ld_addr_i,
    input  logic [7:0] ld_data_i,
    output logic       wr_stb_o,
    output logic [5:0] wr_addr_o,
    output logic [7:0] wr_data_o,
    output logic       busy_o
);
    typedef enum logic [2:0] {S_IDLE, S_CMD, S_ADDR, S_WDATA, S_RDATA, S_IGNORE} state_t;

    state_t      state_q, state_d;
    logic [2:0]  sclk_sync_q, cs_sync_q;
    logic [1:0]  mosi_sync_q;
    logic [1:0]  settle_q;
    logic        armed_q;
    logic [2:0]  bit_cnt_q;
    logic [7:0]  shift_in_q, shift_out_q;
    logic [5:0]  addr_q;
    logic        is_read_q;
    logic        miso_q, busy_q, wr_stb_q;
    logic [5:0]  wr_addr_q;
    logic [7:0]  wr_data_q;
    logic [7:0]  regs_q [0:63];

    logic        sclk_rise, sclk_fall, cs_fall, cs_rise, byte_done;
    logic [7:0]  rx_byte, fetch_data;
    logic [5:0]  fetch_addr;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sclk_sync_q <= 3'b000;
            cs_sync_q   <= 3'b111;
            mosi_sync_q <= 2'b00;
        end else begin
            sclk_sync_q <= {sclk_sync_q[1:0], sclk_i};
            cs_sync_q   <= {cs_sync_q[1:0], cs_n_i};
            mosi_sync_q <= {mosi_sync_q[0], mosi_i};
        end
    end

    // A cs_n pin still low after reset would look like a fresh fall once the
    // synchronizer flushes; only accept falls once cs_n has been seen high.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            settle_q <= 2'd0;
            armed_q  <= 1'b0;
        end else begin
            if (settle_q != 2'd3)
                settle_q <= settle_q + 2'd1;
            if (settle_q == 2'd3 && cs_sync_q[2])
                armed_q <= 1'b1;
        end
    end

    assign sclk_rise = sclk_sync_q[1] & ~sclk_sync_q[2];
    assign sclk_fall = ~sclk_sync_q[1] & sclk_sync_q[2];
    assign cs_fall   = ~cs_sync_q[1] & cs_sync_q[2] & armed_q;
    assign cs_rise   = cs_sync_q[1] & ~cs_sync_q[2];
    assign rx_byte   = {shift_in_q[6:0], mosi_sync_q[1]};
    assign byte_done = sclk_rise && (state_q != S_IDLE) && (bit_cnt_q == 3'd7);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (cs_fall) state_d = S_CMD;
            S_CMD: begin
                if (byte_done)
                    state_d = (rx_byte == 8'h0A || rx_byte == 8'h0B) ? S_ADDR : S_IGNORE;
            end
            S_ADDR: if (byte_done) state_d = is_read_q ? S_RDATA : S_WDATA;
            default: state_d = state_q;
        endcase
        // The rise in this cycle is still processed by the datapath below.
        if (cs_rise)
            state_d = S_IDLE;
    end

    assign fetch_addr = (state_q == S_ADDR) ? rx_byte[5:0] : addr_q;

    always_comb begin
        case (fetch_addr)
            6'd0:    fetch_data = DEVID_AD;
            6'd1:    fetch_data = DEVID_MST;
            6'd2:    fetch_data = PARTID;
            default: fetch_data = regs_q[fetch_addr];
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            bit_cnt_q   <= 3'd0;
            shift_in_q  <= 8'd0;
            shift_out_q <= 8'd0;
            addr_q      <= 6'd0;
            is_read_q   <= 1'b0;
            miso_q      <= 1'b0;
            busy_q      <= 1'b0;
            wr_stb_q    <= 1'b0;
            wr_addr_q   <= 6'd0;
            wr_data_q   <= 8'd0;
            for (int i = 0; i < 64; i++)
                regs_q[i] <= 8'd0;
        end else begin
            wr_stb_q <= 1'b0;
            busy_q   <= armed_q & ~cs_sync_q[1];
            if (ld_en_i && ld_addr_i >= 6'd3)
                regs_q[ld_addr_i] <= ld_data_i;
            if (cs_fall) begin
                bit_cnt_q <= 3'd0;
            end else if (sclk_rise && state_q != S_IDLE) begin
                bit_cnt_q  <= bit_cnt_q + 3'd1;
                shift_in_q <= rx_byte;
            end
            if (byte_done) begin
                case (state_q)
                    S_CMD: is_read_q <= rx_byte[0];
                    S_ADDR: begin
                        if (is_read_q) begin
                            shift_out_q <= fetch_data;
                            addr_q      <= rx_byte[5:0] + 6'd1;
                        end else begin
                            addr_q <= rx_byte[5:0];
                        end
                    end
                    S_WDATA: begin
                        // Placed after the load-port write so SPI wins a collision.
                        if (addr_q >= 6'd3) begin
                            regs_q[addr_q] <= rx_byte;
                            wr_stb_q       <= 1'b1;
                            wr_addr_q      <= addr_q;
                            wr_data_q      <= rx_byte;
                        end
                        addr_q <= addr_q + 6'd1;
                    end
                    S_RDATA: begin
                        shift_out_q <= fetch_data;
                        addr_q      <= addr_q + 6'd1;
                    end
                    default: ;
                endcase
            end else if (sclk_fall && state_q == S_RDATA) begin
                miso_q      <= shift_out_q[7];
                shift_out_q <= {shift_out_q[6:0], 1'b0};
            end
            if (state_d != S_RDATA)
                miso_q <= 1'b0;
        end
    end

    assign miso_o    = miso_q;
    assign miso_oe_o = busy_q;
    assign busy_o    = busy_q;
    assign wr_stb_o  = wr_stb_q;
    assign wr_addr_o = wr_addr_q;
    assign wr_data_o = wr_data_q;
endmodule

// File: tb/tb_spi_slave_regfile.sv
// Bench for spi_slave_regfile: directed protocol scenarios plus random bursts
// checked against an array model of the register file and a strobe queue.
module tb_spi_slave_regfile;
    logic       clk = 1'b0, rst = 1'b1;
    logic       sclk = 1'b0, cs_n = 1'b1, mosi = 1'b0;
    logic       ld_en = 1'b0;
    logic [5:0] ld_addr = '0;
    logic [7:0] ld_data = '0;
    logic       miso, miso_oe, wr_stb, busy;
    logic [5:0] wr_addr;
    logic [7:0] wr_data;

    int n_vec = 0, n_bad = 0;
    logic [7:0]  mem [64];
    logic [13:0] got_q[$], exp_q[$];

    spi_slave_regfile dut (
        .clk_i(clk), .rst_i(rst), .sclk_i(sclk), .cs_n_i(cs_n), .mosi_i(mosi),
        .miso_o(miso), .miso_oe_o(miso_oe), .ld_en_i(ld_en), .ld_addr_i(ld_addr),
        .ld_data_i(ld_data), .wr_stb_o(wr_stb), .wr_addr_o(wr_addr),
        .wr_data_o(wr_data), .busy_o(busy)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (wr_stb) got_q.push_back({wr_addr, wr_data});

    initial begin
        #2ms;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end else begin
            $display("ok   %s: %0h", tag, got);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic cs_low;
        cs_n = 1'b0;
        tick(8);
    endtask

    task automatic cs_high;
        tick(8);
        cs_n = 1'b1;
        tick(8);
    endtask

    // Shift nb bits MSB first; miso is sampled just before each rising edge.
    task automatic spi_bits(input logic [7:0] tx, input int nb, input bit collide,
                            output logic [7:0] rx);
        rx = '0;
        for (int i = 0; i < nb; i++) begin
            mosi = tx[7-i];
            tick(8);
            rx = {rx[6:0], miso};
            sclk = 1'b1;
            if (collide && i == 7) begin
                tick(2);
                ld_en = 1'b1;
                tick(1);
                ld_en = 1'b0;
                tick(5);
            end else begin
                tick(8);
            end
            sclk = 1'b0;
        end
    endtask

    task automatic spi_byte(input logic [7:0] tx, output logic [7:0] rx);
        spi_bits(tx, 8, 1'b0, rx);
    endtask

    task automatic check_strobes(input string tag);
        int n;
        check({tag, "_stb_cnt"}, got_q.size(), exp_q.size());
        n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < n; i++)
            check({tag, "_stb"}, {18'd0, got_q[i]}, {18'd0, exp_q[i]});
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic spi_write(input string tag, input logic [5:0] a, input int len,
                             input logic [7:0] d [4]);
        logic [7:0] rx, acc;
        logic [5:0] ai;
        acc = '0;
        cs_low();
        spi_byte(8'h0A, rx);
        spi_byte({2'($urandom), a}, rx);
        for (int i = 0; i < len; i++) begin
            spi_byte(d[i], rx);
            acc |= rx;
            ai = a + 6'(i);
            if (ai >= 6'd3) begin
                mem[ai] = d[i];
                exp_q.push_back({ai, d[i]});
            end
        end
        cs_high();
        check({tag, "_miso_quiet"}, {24'd0, acc}, 32'd0);
        check_strobes(tag);
    endtask

    task automatic spi_read(input string tag, input logic [5:0] a, input int len);
        logic [7:0] rx;
        logic [5:0] ai;
        cs_low();
        spi_byte(8'h0B, rx);
        spi_byte({2'($urandom), a}, rx);
        for (int i = 0; i < len; i++) begin
            spi_byte(8'($urandom), rx);
            ai = a + 6'(i);
            check({tag, "_rd"}, {24'd0, rx}, {24'd0, mem[ai]});
        end
        cs_high();
    endtask

    task automatic load(input logic [5:0] a, input logic [7:0] d);
        ld_addr = a;
        ld_data = d;
        ld_en = 1'b1;
        tick(1);
        ld_en = 1'b0;
        if (a >= 6'd3) mem[a] = d;
    endtask

    task automatic model_reset;
        for (int i = 3; i < 64; i++) mem[i] = 8'h00;
    endtask

    initial begin
        logic [7:0] d [4];
        logic [7:0] rx, acc;
        mem[0] = 8'hAD; mem[1] = 8'h1D; mem[2] = 8'hF2;
        model_reset();
        tick(3);
        rst = 1'b0;
        tick(2);
        check("rst_miso", {31'd0, miso}, 32'd0);
        check("rst_oe", {31'd0, miso_oe}, 32'd0);
        check("rst_stb", {31'd0, wr_stb}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_wr_addr", {26'd0, wr_addr}, 32'd0);
        check("rst_wr_data", {24'd0, wr_data}, 32'd0);
        tick(4);

        // Read ID burst with explicit constants.
        cs_low();
        check("busy_on", {31'd0, busy}, 32'd1);
        check("oe_on", {31'd0, miso_oe}, 32'd1);
        spi_byte(8'h0B, rx);
        spi_byte(8'h00, rx);
        spi_byte(8'h00, rx); check("id_ad", {24'd0, rx}, 32'hAD);
        spi_byte(8'h00, rx); check("id_mst", {24'd0, rx}, 32'h1D);
        spi_byte(8'h00, rx); check("id_part", {24'd0, rx}, 32'hF2);
        cs_high();
        check("busy_off", {31'd0, busy}, 32'd0);

        // Write then read back.
        d = '{8'h5A, 8'h00, 8'h00, 8'h00};
        spi_write("wr20", 6'h20, 1, d);
        check("wr_addr", {26'd0, wr_addr}, 32'h20);
        check("wr_data", {24'd0, wr_data}, 32'h5A);
        spi_read("rd20", 6'h20, 1);

        // Burst wrap through the read-only registers.
        d = '{8'h11, 8'h22, 8'h33, 8'h44};
        spi_write("wrap", 6'h3F, 4, d);
        spi_read("wrap", 6'h3F, 4);

        // Abort after 5 data bits.
        cs_low();
        spi_byte(8'h0A, rx);
        spi_byte(8'h30, rx);
        spi_bits(8'hFF, 5, 1'b0, rx);
        cs_high();
        check_strobes("abort");
        spi_read("abort", 6'h30, 1);

        // Unknown command.
        acc = '0;
        cs_low();
        spi_byte(8'h55, rx);
        for (int i = 0; i < 3; i++) begin
            spi_byte(8'($urandom), rx);
            acc |= rx;
        end
        cs_high();
        check("unk_miso", {24'd0, acc}, 32'd0);
        check_strobes("unk");

        // Load-port collision with an SPI commit to the same address.
        cs_low();
        spi_byte(8'h0A, rx);
        spi_byte(8'h10, rx);
        ld_addr = 6'h10;
        ld_data = 8'h40;
        spi_bits(8'h99, 8, 1'b1, rx);
        mem[6'h10] = 8'h99;
        exp_q.push_back({6'h10, 8'h99});
        cs_high();
        check_strobes("coll");
        spi_read("coll", 6'h10, 1);
        load(6'h10, 8'h40);
        spi_read("ld", 6'h10, 1);
        load(6'h01, 8'h77);
        spi_read("ld_ro", 6'h01, 1);

        // Randomized mix of transactions.
        for (int t = 0; t < 30; t++) begin
            int kind, len;
            logic [5:0] a;
            kind = $urandom_range(0, 3);
            len = $urandom_range(1, 4);
            a = 6'($urandom);
            for (int k = 0; k < 4; k++) d[k] = 8'($urandom);
            case (kind)
                0: spi_write("rnd", a, len, d);
                1: spi_read("rnd", a, len);
                2: begin
                    load(a, d[0]);
                    spi_read("rnd_ld", a, 1);
                end
                default: begin
                    acc = '0;
                    cs_low();
                    spi_byte(8'h01 + 8'($urandom_range(0, 8)), rx);
                    spi_byte(8'($urandom), rx); acc |= rx;
                    cs_high();
                    check("rnd_unk_miso", {24'd0, acc}, 32'd0);
                    check_strobes("rnd_unk");
                end
            endcase
        end

        // Reset in the middle of a read data byte.
        cs_low();
        spi_byte(8'h0B, rx);
        spi_byte(8'h00, rx);
        spi_bits(8'h00, 3, 1'b0, rx);
        rst = 1'b1;
        #1;
        check("rst_mid_oe", {31'd0, miso_oe}, 32'd0);
        check("rst_mid_miso", {31'd0, miso}, 32'd0);
        tick(2);
        rst = 1'b0;
        model_reset();
        tick(4);
        acc = '0;
        for (int i = 0; i < 2; i++) begin
            spi_byte(8'h0A, rx);
            acc |= rx;
        end
        check("rst_no_resp", {24'd0, acc}, 32'd0);
        check_strobes("rst_mid");
        cs_high();
        spi_read("post_rst_id", 6'h00, 1);
        spi_read("post_rst_reg", 6'h20, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule

// File: doc/spi_slave_regfile.md
# spi_slave_regfile

SPI mode-0 responder with a 64-byte register file, modelling the register side of the PmodACL2 (ADXL362-style) command protocol. It sits at the far end of the SPI link driven by the system controller's `sclk_o`. It oversamples `sclk`, `cs_n` and `mosi` in the `clk_i` domain, decodes read and write commands, and serves burst register accesses. A fabric-side load port lets logic update data registers, and a write strobe reports every SPI register write.

## Interface

Parameters:
- `DEVID_AD`, 8'hAD, read-only register 0x00 value
- `DEVID_MST`, 8'h1D, read-only register 0x01 value
- `PARTID`, 8'hF2, read-only register 0x02 value

Ports:
- `clk_i`  in  1  system clock
- `rst_i`  in  1  reset, asynchronous, active-high
- `sclk_i`  in  1  SPI clock, asynchronous to `clk_i`
- `cs_n_i`  in  1  SPI chip select, active-low, asynchronous
- `mosi_i`  in  1  SPI data in, asynchronous
- `miso_o`  out  1  SPI data out
- `miso_oe_o`  out  1  output enable for `miso`
- `ld_en_i`  in  1  fabric register load strobe
- `ld_addr_i`  in  6  fabric load address
- `ld_data_i`  in  8  fabric load data
- `wr_stb_o`  out  1  one-cycle pulse per committed SPI register write
- `wr_addr_o`  out  6  address of the last SPI write
- `wr_data_o`  out  8  data of the last SPI write
- `busy_o`  out  1  synchronized chip select is active

## Operation

**Synchronization**
- `sclk_i`, `cs_n_i` and `mosi_i` each pass through a 2-flop synchronizer.
- A third flop on `sclk` and on `cs_n` provides edge detection.
- Detected events: sclk rise, sclk fall, cs fall, cs rise.
- Each sclk half-period must be at least 4 `clk_i` cycles. With the system controller's divide-by-16 SCLK this is met.

**Protocol (SPI mode 0, MSB first)**
- `mosi` is sampled on sclk rise. `miso` changes on sclk fall.
- Command byte:
  - 0x0A = register write.
  - 0x0B = register read.
  - Any other value = ignore.
- The address byte follows the command byte. Address bits [5:0] are used and bits [7:6] are ignored.
- The data bytes follow the address byte. Bursts auto-increment the address modulo 64, so 0x3F is followed by 0x00.

**FSM states**
- IDLE: waiting for cs fall. Cs fall → CMD, with the bit counter cleared.
- CMD: on the 8th rise, go to ADDR if the byte is 0x0A or 0x0B, otherwise go to IGNORE.
- ADDR: on the 8th rise, latch the address, then go to WDATA (write command) or RDATA (read command).
- WDATA: on each 8th rise, commit the byte to `reg[addr]` and increment `addr`.
- RDATA: on each 8th rise (including the address byte's 8th rise), fetch `reg[addr]` into the shift register, then increment `addr`.
- IGNORE: `mosi` is discarded.
- From any state, cs rise → IDLE. A partial byte is discarded with no write and no strobe.

**Read path**
- The fetched byte's MSB drives `miso_o` at the next sclk fall. Each following sclk fall shifts out the next bit.
- `miso_o` = 0 in every state other than RDATA.
- `miso_oe_o` = 1 while cs is active (synchronized), otherwise 0.

**Register file**
- 0x00–0x02 are read-only and return the parameter values.
- SPI writes to 0x00–0x02 are dropped: no strobe is issued, but the address still increments.
- All other registers are writable from SPI and from the load port. `ld_en_i` writes to 0x00–0x02 are ignored.
- If an SPI commit and `ld_en_i` target the same address in the same cycle, the SPI write wins.
- An SPI read returns the value present in the cycle of the fetch.

**Reset**
- All registers 0x03–0x3F = 0x00.
- State = IDLE.
- Synchronizers are reset to sclk=0, cs_n=1, mosi=0.
- Outputs `miso_o`, `miso_oe_o`, `wr_stb_o`, `busy_o` = 0. `wr_addr_o` = 0, `wr_data_o` = 0.
- If reset occurs mid-transaction, the block does not resume. It waits for a fresh cs fall.

## Timing

- Input-to-event latency: 3 `clk_i` cycles from a pin edge to the detected event.
- `busy_o` asserts 3 cycles after `cs_n_i` falls and deasserts 3 cycles after it rises.
- Write commit: register, `wr_addr_o` and `wr_data_o` update, and `wr_stb_o` pulses high for exactly 1 cycle, in the cycle after the detected 8th rise of a data byte.
- `miso_o` updates 1 cycle after the detected sclk fall. Worst case this is 4 cycles after the pin edge, which is well within the 8-cycle half-period.
- A cs rise in the same cycle as a detected 8th rise: the rise completes first (commit or fetch happens), then the state returns to IDLE.
- Simultaneous sclk and cs events cannot occur under mode-0 usage. If they do, cs takes priority.

## Test plan

1. Read ID burst: cs low, send 0x0B 0x00, then 3 dummy bytes → `miso` returns 0xAD, 0x1D, 0xF2.
2. Write then read back:
   - Send 0x0A 0x20 0x5A → `wr_stb_o` pulses once, with `wr_addr_o`=0x20 and `wr_data_o`=0x5A.
   - Send 0x0B 0x20 → `miso` returns 0x5A.
3. Burst wrap: write 0x0A 0x3F 0x11 0x22 0x33 0x44.
   - Reg 0x3F = 0x11.
   - Regs 0x00–0x02 are unchanged and issue no strobes.
   - Exactly 1 strobe is issued for the 4 data bytes (address 0x3F).
4. Abort and unknown command:
   - Raise cs after 5 bits of the data byte in 0x0A 0x30 → no strobe, reg 0x30 unchanged.
   - Command 0x55 → `miso` = 0 throughout, no writes.
5. Load collision: `ld_en_i` writes 0x40 to 0x10 in the same cycle as an SPI commit of 0x99 to 0x10 → reg 0x10 = 0x99. A later `ld_en_i` write of 0x40 → read returns 0x40.
6. Reset mid-read: assert `rst_i` during the data byte of a 0x0B read → `miso_oe_o`=0 immediately. Resuming sclk without a new cs fall → no response. A new 0x0B 0x00 → 0xAD.
